// File: rtl/res_station_if.sv
// Reservation station cell type and the dispatch/CDB/issue bundle shared by
// the station, its dispatch producer and the execute consumer.
package res_station_pkg;
  localparam int TAG_W = 4;

  typedef struct packed {
    logic [7:0]       op;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [31:0]      a;
    logic [31:0]      pc;
  } res_st_cell_t;
endpackage

interface res_station_if #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_WIDTH   = res_station_pkg::TAG_W
);
  import res_station_pkg::*;
  localparam int CW = $clog2(NUM_ENTRIES + 1);

  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  res_st_cell_t         in_cell;
  logic                 cdb_valid;
  logic [TAG_WIDTH-1:0] cdb_tag;
  logic [31:0]          cdb_value;
  logic                 out_valid;
  logic                 out_ready;
  res_st_cell_t         out_cell;
  logic [CW-1:0]        count;

  modport master (
    output flush, in_valid, in_cell, cdb_valid, cdb_tag, cdb_value, out_ready,
    input  in_ready, out_valid, out_cell, count
  );
  modport slave (
    input  flush, in_valid, in_cell, cdb_valid, cdb_tag, cdb_value, out_ready,
    output in_ready, out_valid, out_cell, count
  );
endinterface

// File: rtl/res_station.sv
// Collapsing-queue reservation station: slot 0 is oldest, CDB wakeup with
// allocation bypass, oldest-ready issue with shift-down compaction.
module res_station #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_WIDTH   = res_station_pkg::TAG_W
) (
  input logic          clk,
  input logic          rst_n,
  res_station_if.slave bus
);
  import res_station_pkg::*;
  localparam int CW = $clog2(NUM_ENTRIES + 1);
  localparam int SW = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0] valid, valid_nxt, valid_sh, rdy;
  res_st_cell_t           cells[NUM_ENTRIES];
  res_st_cell_t           cells_nxt[NUM_ENTRIES];
  res_st_cell_t           cap[NUM_ENTRIES];
  res_st_cell_t           cap_sh[NUM_ENTRIES];
  res_st_cell_t           in_cap;
  logic [CW-1:0]          count_q, count_nxt, pos;
  logic [SW-1:0]          sel;
  logic                   alloc, issue;

  function automatic res_st_cell_t wake(res_st_cell_t c, logic v,
                                        logic [TAG_WIDTH-1:0] t, logic [31:0] d);
    res_st_cell_t r;
    r = c;
    if (v && t != '0) begin
      if (c.qj == t) begin r.vj = d; r.qj = '0; end
      if (c.qk == t) begin r.vk = d; r.qk = '0; end
    end
    return r;
  endfunction

  // cap[] is each slot after this cycle's broadcast; cap_sh[] is the view
  // from one slot higher, used when an issue compacts the queue.
  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_slot
    assign cap[i] = wake(cells[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
    assign rdy[i] = valid[i] && cells[i].qj == '0 && cells[i].qk == '0;
    if (i < NUM_ENTRIES - 1) begin : g_sh
      assign cap_sh[i]   = cap[i+1];
      assign valid_sh[i] = valid[i+1];
    end else begin : g_top
      assign cap_sh[i]   = cap[i];
      assign valid_sh[i] = 1'b0;
    end
  end

  assign in_cap = wake(bus.in_cell, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);

  always_comb begin
    sel = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--)
      if (rdy[i]) sel = SW'(i);
  end

  assign bus.out_valid = |rdy;
  assign bus.out_cell  = cells[sel];
  assign bus.in_ready  = count_q < CW'(NUM_ENTRIES);
  assign bus.count     = count_q;
  assign alloc = bus.in_valid && bus.in_ready;
  assign issue = bus.out_valid && bus.out_ready;
  assign pos   = count_q - CW'(issue);

  always_comb begin
    valid_nxt = valid;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      cells_nxt[i] = cap[i];
      if (issue && i >= int'(sel)) begin
        cells_nxt[i] = cap_sh[i];
        valid_nxt[i] = valid_sh[i];
      end
      if (alloc && CW'(i) == pos) begin
        cells_nxt[i] = in_cap;
        valid_nxt[i] = 1'b1;
      end
    end
    count_nxt = count_q + CW'(alloc) - CW'(issue);
    if (bus.flush) begin
      valid_nxt = '0;
      count_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= '0;
      count_q <= '0;
    end else begin
      valid   <= valid_nxt;
      count_q <= count_nxt;
    end
  end

  // Payload is qualified by valid, so it carries no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENTRIES; i++) cells[i] <= cells_nxt[i];
  end
endmodule

// File: tb/tb_res_station.sv
// Directed scenarios plus randomized traffic against a queue-level model of
// the station; every cycle compares handshake, selected cell and occupancy.
module tb_res_station;
  import res_station_pkg::*;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  res_st_cell_t mq[$];

  res_station_if #(.NUM_ENTRIES(N), .TAG_WIDTH(TAG_W)) bus();
  res_station #(.NUM_ENTRIES(N), .TAG_WIDTH(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [191:0] got, logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic res_st_cell_t mk(logic [31:0] vj, logic [31:0] vk,
                                      logic [3:0] qj, logic [3:0] qk);
    res_st_cell_t c;
    c.op = 8'($urandom); c.vj = vj; c.vk = vk; c.qj = qj; c.qk = qk;
    c.a = $urandom; c.pc = $urandom;
    return c;
  endfunction

  function automatic res_st_cell_t grab(res_st_cell_t c, logic v, logic [3:0] t,
                                        logic [31:0] d);
    if (v && t != 0 && c.qj == t) begin c.vj = d; c.qj = 0; end
    if (v && t != 0 && c.qk == t) begin c.vk = d; c.qk = 0; end
    return c;
  endfunction

  // One cycle: drive, compare against the model, then advance the model.
  task automatic step(logic iv, res_st_cell_t c, logic cv, logic [3:0] ct,
                      logic [31:0] cval, logic ordy, logic fl);
    int idx;
    logic room;
    @(negedge clk);
    bus.in_valid = iv; bus.in_cell = c; bus.cdb_valid = cv; bus.cdb_tag = ct;
    bus.cdb_value = cval; bus.out_ready = ordy; bus.flush = fl;
    #1;
    idx = -1;
    foreach (mq[i]) if (idx < 0 && mq[i].qj == 0 && mq[i].qk == 0) idx = i;
    room = mq.size() < N;
    chk("count", 192'(bus.count), 192'(mq.size()));
    chk("in_ready", 192'(bus.in_ready), 192'(room));
    chk("out_valid", 192'(bus.out_valid), 192'(idx >= 0));
    if (idx >= 0) chk("out_cell", 192'(bus.out_cell), 192'(mq[idx]));
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (idx >= 0 && ordy) mq.delete(idx);
      foreach (mq[i]) mq[i] = grab(mq[i], cv, ct, cval);
      if (iv && room) mq.push_back(grab(c, cv, ct, cval));
    end
  endtask

  task automatic idle(logic ordy);
    step(1'b0, '0, 1'b0, 4'd0, 32'd0, ordy, 1'b0);
  endtask

  task automatic put(res_st_cell_t c, logic ordy);
    step(1'b1, c, 1'b0, 4'd0, 32'd0, ordy, 1'b0);
  endtask

  initial begin
    res_st_cell_t c;
    bus.flush = 0; bus.in_valid = 0; bus.in_cell = '0; bus.cdb_valid = 0;
    bus.cdb_tag = 0; bus.cdb_value = 0; bus.out_ready = 0;
    #12;
    chk("rst_count", 192'(bus.count), 192'(0));
    chk("rst_out_valid", 192'(bus.out_valid), 192'(0));
    chk("rst_in_ready", 192'(bus.in_ready), 192'(1));
    @(negedge clk); rst_n = 1'b1;

    // A: ready cell issues the cycle after allocation
    c = mk(32'd5, 32'd1, 4'd0, 4'd0); c.a = 32'd7;
    put(c, 1'b1);
    #2;
    chk("a_valid", 192'(bus.out_valid), 192'(1));
    chk("a_vj", 192'(bus.out_cell.vj), 192'(5));
    chk("a_a", 192'(bus.out_cell.a), 192'(7));
    chk("a_count1", 192'(bus.count), 192'(1));
    idle(1'b1);
    #2 chk("a_count0", 192'(bus.count), 192'(0));

    // B waits on tag 3, younger C overtakes it
    put(mk(32'd0, 32'd2, 4'd3, 4'd0), 1'b0);
    c = mk(32'h1234, 32'd3, 4'd0, 4'd0);
    put(c, 1'b0);
    #2 chk("c_first", 192'(bus.out_cell.vj), 192'(32'h1234));
    idle(1'b1);
    step(1'b0, '0, 1'b1, 4'd3, 32'hDEAD, 1'b0, 1'b0);
    #2;
    chk("b_valid", 192'(bus.out_valid), 192'(1));
    chk("b_vj", 192'(bus.out_cell.vj), 192'(32'hDEAD));
    chk("b_qj", 192'(bus.out_cell.qj), 192'(0));
    idle(1'b1);

    // D captures through the allocation bypass
    step(1'b1, mk(32'd4, 32'd0, 4'd0, 4'd2), 1'b1, 4'd2, 32'd9, 1'b0, 1'b0);
    #2;
    chk("d_valid", 192'(bus.out_valid), 192'(1));
    chk("d_vk", 192'(bus.out_cell.vk), 192'(9));
    idle(1'b1);

    // Fill, overflow attempt, wake all, drain in order
    for (int i = 0; i < N; i++) put(mk(32'd0, 32'(i), 4'd1, 4'd0), 1'b0);
    #2;
    chk("full_count", 192'(bus.count), 192'(N));
    chk("full_in_ready", 192'(bus.in_ready), 192'(0));
    put(mk(32'd0, 32'd0, 4'd0, 4'd0), 1'b1);
    step(1'b0, '0, 1'b1, 4'd1, 32'hBEEF, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) idle(1'b1);

    // Flush with concurrent dispatch
    for (int i = 0; i < 3; i++) put(mk(32'd0, 32'd0, 4'd2, 4'd2), 1'b0);
    step(1'b1, mk(32'd1, 32'd1, 4'd0, 4'd0), 1'b0, 4'd0, 32'd0, 1'b1, 1'b1);
    #2;
    chk("flush_count", 192'(bus.count), 192'(0));
    chk("flush_out_valid", 192'(bus.out_valid), 192'(0));

    // Tag 0 broadcast never wakes
    put(mk(32'd0, 32'd0, 4'd2, 4'd0), 1'b0);
    step(1'b0, '0, 1'b1, 4'd0, 32'h55, 1'b1, 1'b0);
    #2 chk("tag0_out_valid", 192'(bus.out_valid), 192'(0));
    put(mk(32'd0, 32'd0, 4'd3, 4'd0), 1'b0);

    // Asynchronous reset mid-cycle
    @(negedge clk);
    bus.in_valid = 0; bus.cdb_valid = 0; bus.out_ready = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 192'(bus.count), 192'(0));
    chk("arst_out_valid", 192'(bus.out_valid), 192'(0));
    chk("arst_in_ready", 192'(bus.in_ready), 192'(1));
    mq.delete();
    @(negedge clk); rst_n = 1'b1;

    for (int n = 0; n < 2000; n++) begin
      logic [3:0] qj, qk;
      qj = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 3));
      qk = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 3));
      step($urandom_range(0, 9) < 7, mk($urandom, $urandom, qj, qk),
           $urandom_range(0, 2) == 0, 4'($urandom_range(0, 3)), $urandom,
           $urandom_range(0, 1) == 1, $urandom_range(0, 49) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/res_station.md
# res_station

Reservation station feeding the execute stage: it buffers dispatched micro-ops as `res_st_cell_t` entries and captures missing source operands from the common data bus (CDB). It issues the oldest entry whose operands are all ready to execute through a valid/ready handshake. It sits between dispatch/rename and `execute`, and is the producer of the `res_st_cell_t` that `execute` consumes.

## Interface
Parameters:
- `NUM_ENTRIES`, 4: entry count, ≥2.
- `TAG_WIDTH`, 4: width of the producer tag (ROB index).
  - Tag 0 is reserved and means "operand present".

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of all entries (mispredict).
- `in_valid`  in  1  dispatch offers `in_cell`.
- `in_ready`  out  1  station can accept; equals `count < NUM_ENTRIES`.
- `in_cell`  in  `res_st_cell_t`  dispatched op.
  - Fields used: `op`, `vj`, `vk`, `qj`, `qk`, `a`, `pc`.
- `cdb_valid`  in  1  broadcast valid.
- `cdb_tag`  in  `TAG_WIDTH`  producing tag.
- `cdb_value`  in  32  produced value.
- `out_valid`  out  1  a ready entry is offered to execute.
- `out_ready`  in  1  execute accepts.
- `out_cell`  out  `res_st_cell_t`  selected entry, with `qj`/`qk` = 0.
- `count`  out  `$clog2(NUM_ENTRIES+1)`  occupied entries.

## Operation
- Storage is a collapsing queue: slot 0 is the oldest entry. Each slot holds a valid bit and a `res_st_cell_t`.
- Allocation happens on `in_valid && in_ready`. The cell is written to slot `count`, or to slot `count-1` if an issue happens in the same cycle.
- CDB capture when `cdb_valid` and `cdb_tag != 0`:
  - For every valid entry with `qj == cdb_tag`: set `vj <= cdb_value` and `qj <= 0`.
  - Apply the same rule independently for `qk`/`vk`.
- Same-cycle bypass on allocation: if the incoming `in_cell.qj` (or `qk`) matches a valid CDB tag, the entry is stored already captured.
- `cdb_tag == 0` is ignored.
- Ready rule: an entry is ready when it is valid, `qj == 0` and `qk == 0`.
- Select: the lowest-index ready slot, i.e. the oldest.
  - `out_valid` = any ready slot.
  - `out_cell` is driven combinationally from the selected slot.
- Issue: on `out_valid && out_ready`, the selected slot is removed and all younger slots shift down by one. Age order is preserved.
- `out_cell` must be stable while `out_valid && !out_ready`, unless an older entry becomes ready.
  - A newly ready older entry preempts the offered one; `execute` is combinational, so this is permitted.
- `count` updates as `count + alloc - issue` and never exceeds `NUM_ENTRIES`.
- `flush`:
  - All valid bits clear on the next edge.
  - Any allocation and issue in the same cycle are discarded.
  - `count` becomes 0.
- Reset (`rst_n` low, asynchronous):
  - All valid bits cleared, `count` = 0.
  - Hence `out_valid` = 0 and `in_ready` = 1.
  - Payload registers need not be reset.

## Timing
- Allocation-to-issue latency: 1 cycle.
  - A cell with `qj = qk = 0` accepted at edge N can be offered with `out_valid` during cycle N+1.
- Wakeup latency: 1 cycle.
  - A CDB broadcast in cycle N (sampled at edge N+1) makes the entry ready in cycle N+1.
  - This also holds when the wakeup arrives via the allocation bypass.
- Full:
  - `in_ready` = 0 when `count == NUM_ENTRIES`, even if `out_ready` = 1 in that cycle.
  - There is no same-cycle refill when full.
- Empty: `out_valid` = 0. A cell allocated in cycle N is never issued in cycle N.
- Issue and CDB capture in the same cycle:
  - The issued entry is already ready, so capture does not affect it.
  - Shifted entries keep any values captured that cycle.
- Issue and allocation in the same cycle: `count` is unchanged, and the new cell lands behind all survivors.
- Reset deassertion is synchronized externally. The first allocation is accepted on the first edge with `rst_n` high.

## Test plan
- Reset, then dispatch cell A (`qj=qk=0`, `vj=5`, `a=7`) with `out_ready=1`.
  - Required: `out_valid` in cycle 1 with `vj=5`; `count` goes 1→0; `in_ready` stays 1.
- Dispatch B (`qj=3`), then C (`qj=qk=0`).
  - Required: C issues first.
  - Then broadcast `cdb_tag=3`, `cdb_value=0xDEAD`: B issues the next cycle with `vj=0xDEAD`, `qj=0`.
- Dispatch D with `qk=2` in the same cycle as `cdb_valid=1`, `cdb_tag=2`, `cdb_value=9`.
  - Required: D is offered next cycle with `vk=9`.
- Fill all 4 entries with `qj=1` and `out_ready=0`.
  - Required: `in_ready=0`, `count=4`, `in_valid` ignored.
  - Broadcast tag 1: entries issue in allocation order, one per cycle, each with the captured value.
- With 3 entries held, pulse `flush` together with `in_valid`.
  - Required: `count=0` next cycle, `out_valid=0`, the dispatched cell is not stored.
- Assert `rst_n` low mid-operation with 2 entries.
  - Required: `count=0` and `out_valid=0` immediately, without waiting for a clock edge.
  - `cdb_tag=0` broadcasts never wake entries.
